// File: rtl/axi_dma_r_burst_pkg.sv
// Shared AXI constants, FSM state codes and the error flag layout for the burst read DMA.
package axi_dma_r_burst_pkg;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_CACHE_W = 4;
  localparam int AXI_PROT_W  = 3;
  localparam int AXI_QOS_W   = 4;
  localparam int AXI_RESP_W  = 2;

  localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [AXI_CACHE_W-1:0] AXI_CACHE_MOD  = 4'h2;
  localparam logic [AXI_PROT_W-1:0]  AXI_PROT_DATA  = 3'b010;
  localparam int                     AXI_4K_BYTES   = 4096;

  localparam int R_STATES_W = 2;
  typedef enum logic [R_STATES_W-1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } r_state_e;

  // err[1] = RLAST mismatch, err[0] = non-OKAY RRESP
  typedef struct packed {
    logic last_mis;
    logic resp;
  } err_t;
endpackage

// File: rtl/axi_dma_r_burst_if.sv
// AXI4 read-address and read-data channels between the DMA master and its slave port.
interface axi_dma_r_burst_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 256,
  parameter int ID_W   = 1,
  parameter int LEN_W  = 8
);
  import axi_dma_r_burst_pkg::*;

  logic [ID_W-1:0]        arid;
  logic [ADDR_W-1:0]      araddr;
  logic [LEN_W-1:0]       arlen;
  logic [AXI_SIZE_W-1:0]  arsize;
  logic [AXI_BURST_W-1:0] arburst;
  logic                   arlock;
  logic [AXI_CACHE_W-1:0] arcache;
  logic [AXI_PROT_W-1:0]  arprot;
  logic [AXI_QOS_W-1:0]   arqos;
  logic                   arvalid;
  logic                   arready;

  logic [ID_W-1:0]        rid;
  logic [DATA_W-1:0]      rdata;
  logic [AXI_RESP_W-1:0]  rresp;
  logic                   rlast;
  logic                   rvalid;
  logic                   rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_dma_r_burst_calc.sv
// Next burst size: min(remaining beats, MAX_BURST, beats left before the 4 KB boundary).
module axi_dma_r_burst_calc
  import axi_dma_r_burst_pkg::*;
#(
  parameter int BYTES     = 32,
  parameter int MAX_BURST = 16,
  parameter int NBEATS_W  = 16
) (
  input  logic [NBEATS_W-1:0] remaining,
  input  logic [11:0]         addr_lo,
  output logic [NBEATS_W-1:0] burst
);
  localparam int OFF_W = $clog2(BYTES);

  logic [12:0]         bytes_to_4k;
  logic [NBEATS_W-1:0] beats_to_4k;
  logic [NBEATS_W-1:0] cap;

  always_comb begin
    bytes_to_4k = 13'(AXI_4K_BYTES) - {1'b0, addr_lo};
    beats_to_4k = NBEATS_W'(bytes_to_4k >> OFF_W);
    cap         = (remaining < NBEATS_W'(MAX_BURST)) ? remaining : NBEATS_W'(MAX_BURST);
    burst       = (beats_to_4k < cap) ? beats_to_4k : cap;
  end
endmodule

// File: rtl/axi_dma_r_burst.sv
// AXI4 read DMA master: splits one N-beat transfer into 4K-safe INCR bursts and
// streams the read data out with backpressure; one burst outstanding at a time.
module axi_dma_r_burst
  import axi_dma_r_burst_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 256,
  parameter int ID_W      = 1,
  parameter int LEN_W     = 8,
  parameter int MAX_BURST = 16,
  parameter int NBEATS_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [NBEATS_W-1:0] req_nbeats,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  output logic                done,
  output logic [1:0]          err,
  axi_dma_r_burst_if.master   m_axi
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  r_state_e            state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NBEATS_W-1:0] remaining_q, remaining_d;
  logic [NBEATS_W-1:0] burst_q, burst_d;
  logic [NBEATS_W-1:0] burst_c;
  logic [LEN_W:0]      beat_cnt_q, beat_cnt_d;
  err_t                err_q, err_d;
  logic                r_fire;
  logic                burst_end;
  logic                unused_ok;

  axi_dma_r_burst_calc #(
    .BYTES    (BYTES),
    .MAX_BURST(MAX_BURST),
    .NBEATS_W (NBEATS_W)
  ) u_calc (
    .remaining(remaining_q),
    .addr_lo  (addr_q[11:0]),
    .burst    (burst_c)
  );

  assign r_fire    = (state_q == ST_DATA) && m_axi.rvalid && out_ready;
  assign burst_end = NBEATS_W'(beat_cnt_q) == (burst_q - NBEATS_W'(1));
  assign unused_ok = ^{m_axi.rid, req_addr[OFF_W-1:0]};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    burst_d     = burst_q;
    beat_cnt_d  = beat_cnt_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        addr_d      = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        remaining_d = req_nbeats;
        err_d       = '0;
        state_d     = (req_nbeats == '0) ? ST_DONE : ST_ADDR;
      end
      ST_ADDR: if (m_axi.arready) begin
        burst_d    = burst_c;
        beat_cnt_d = '0;
        state_d    = ST_DATA;
      end
      ST_DATA: if (r_fire) begin
        if (m_axi.rresp != 2'b00) err_d.resp = 1'b1;
        if (burst_end) begin
          if (!m_axi.rlast) err_d.last_mis = 1'b1;
          addr_d      = addr_q + (ADDR_W'(burst_q) << OFF_W);
          remaining_d = remaining_q - burst_q;
          state_d     = (remaining_q == burst_q) ? ST_DONE : ST_ADDR;
        end else begin
          // early RLAST is flagged but the beat count still governs the burst
          if (m_axi.rlast) err_d.last_mis = 1'b1;
          beat_cnt_d = beat_cnt_q + (LEN_W+1)'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      burst_q     <= '0;
      beat_cnt_q  <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      burst_q     <= burst_d;
      beat_cnt_q  <= beat_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    m_axi.arid    = '0;
    m_axi.araddr  = addr_q;
    m_axi.arlen   = LEN_W'(burst_c - NBEATS_W'(1));
    m_axi.arsize  = AXI_SIZE_W'(OFF_W);
    m_axi.arburst = AXI_BURST_INCR;
    m_axi.arlock  = 1'b0;
    m_axi.arcache = AXI_CACHE_MOD;
    m_axi.arprot  = AXI_PROT_DATA;
    m_axi.arqos   = '0;
    m_axi.arvalid = (state_q == ST_ADDR);
    m_axi.rready  = (state_q == ST_DATA) && out_ready;
    req_ready     = (state_q == ST_IDLE);
    out_valid     = (state_q == ST_DATA) && m_axi.rvalid;
    out_data      = m_axi.rdata;
    out_last      = out_valid && burst_end && (remaining_q == burst_q);
    done          = (state_q == ST_DONE);
    err           = err_q;
  end
endmodule

// File: tb/tb_axi_dma_r_burst.sv
// Directed bench: table of transfers against a behavioural AXI slave and consumer,
// plus hand-written reset sequences.
module tb_axi_dma_r_burst;
  localparam int ADDR_W = 32, DATA_W = 256, ID_W = 1, LEN_W = 8;
  localparam int MAX_BURST = 16, NBEATS_W = 16, BYTES = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [ADDR_W-1:0]   req_addr = '0;
  logic [NBEATS_W-1:0] req_nbeats = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [DATA_W-1:0]   out_data;
  logic                out_last;
  logic                done;
  logic [1:0]          err;

  axi_dma_r_burst_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W)) m_axi ();

  axi_dma_r_burst #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W),
    .MAX_BURST(MAX_BURST), .NBEATS_W(NBEATS_W)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_nbeats(req_nbeats),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .done(done), .err(err), .m_axi(m_axi)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          nbeats;
    bit          rnd;
    int          ar_dly;
    int          resp_beat;
    int          nolast_burst;
    int          early_last_beat;
    int          exp_nar;
    logic [31:0] exp_a0;
    int          exp_l0;
    logic [31:0] exp_an;
    int          exp_ln;
    logic [1:0]  exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic idle_inputs();
    m_axi.arready = 1'b0; m_axi.rvalid = 1'b0; m_axi.rlast = 1'b0;
    m_axi.rresp = 2'b00; m_axi.rdata = '0; m_axi.rid = '0;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " req_ready"}, req_ready, 1);
    chk({tag, " arvalid"}, m_axi.arvalid, 0);
    chk({tag, " rready"}, m_axi.rready, 0);
    chk({tag, " out_valid"}, out_valid, 0);
    chk({tag, " out_last"}, out_last, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " err"}, err, 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v, input logic [1:0] prev_err);
    int nar = 0, nbeat = 0, ndone = 0, cyc = 0, last_cyc = -1, done_cyc = -1;
    int ar_cnt = 0, burst_idx = 0, s_len = 0, s_k = 0, l0 = 0, ln = 0;
    logic [31:0] a0 = '0, an = '0, s_addr = '0, h_addr = '0;
    logic [31:0] base;
    logic [7:0] h_len = '0;
    logic [1:0] err_at_done = '0;
    bit s_act = 0, hold = 0;
    bit data_ok = 1, last_ok = 1, rr_ok = 1, ov_ok = 1, stab_ok = 1, shape_ok = 1;
    string t;
    t = $sformatf("v%0d", idx);
    base = v.addr & ~32'h1F;
    @(posedge clk); #1;
    chk({t, " req_ready"}, req_ready, 1);
    chk({t, " err held until accept"}, err, prev_err);
    req_valid = 1'b1; req_addr = v.addr; req_nbeats = NBEATS_W'(v.nbeats);
    while (cyc < 3000 && !(done_cyc >= 0 && cyc >= done_cyc + 2)) begin
      m_axi.arready = m_axi.arvalid && !s_act && (ar_cnt >= v.ar_dly);
      if (s_act) begin
        m_axi.rvalid = v.rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        m_axi.rdata  = {8{s_addr + 32'(s_k * BYTES)}};
        m_axi.rresp  = (nbeat == v.resp_beat) ? 2'b10 : 2'b00;
        m_axi.rlast  = (s_k == s_len) ? (burst_idx != v.nolast_burst) : (nbeat == v.early_last_beat);
      end else begin
        m_axi.rvalid = 1'b0; m_axi.rlast = 1'b0; m_axi.rresp = 2'b00; m_axi.rdata = '0;
      end
      out_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      rr_ok   &= (m_axi.rready == (s_act ? out_ready : 1'b0));
      ov_ok   &= (out_valid == (s_act && m_axi.rvalid));
      last_ok &= (out_last == (s_act && m_axi.rvalid && nbeat == v.nbeats - 1));
      if (s_act && m_axi.arvalid) shape_ok = 0;
      if (s_act && m_axi.rvalid && out_ready) begin
        data_ok &= (out_data == {8{base + 32'(nbeat * BYTES)}});
        if (nbeat == v.nbeats - 1) last_cyc = cyc;
        nbeat++; s_k++;
        if (s_k > s_len) begin s_act = 0; burst_idx++; end
      end
      if (hold) stab_ok &= m_axi.arvalid && (m_axi.araddr == h_addr) && (m_axi.arlen == h_len);
      hold = m_axi.arvalid && !m_axi.arready;
      h_addr = m_axi.araddr; h_len = m_axi.arlen;
      if (m_axi.arvalid && m_axi.arready) begin
        if (nar == 0) begin a0 = m_axi.araddr; l0 = int'(m_axi.arlen); end
        an = m_axi.araddr; ln = int'(m_axi.arlen); nar++;
        shape_ok &= (m_axi.arlen <= 8'd15) &&
                    (int'(m_axi.araddr[11:0]) + (int'(m_axi.arlen) + 1) * BYTES <= 4096) &&
                    (m_axi.arsize == 3'd5) && (m_axi.arburst == 2'b01) && (m_axi.arcache == 4'h2) &&
                    (m_axi.arprot == 3'b010) && (m_axi.arqos == 4'h0) && !m_axi.arlock && (m_axi.arid == '0);
        s_act = 1; s_addr = m_axi.araddr; s_len = int'(m_axi.arlen); s_k = 0; ar_cnt = 0;
      end else if (m_axi.arvalid) ar_cnt++;
      if (done) begin ndone++; done_cyc = cyc; err_at_done = err; end
      @(posedge clk); #1;
      req_valid = 1'b0;
      cyc++;
    end
    idle_inputs();
    chk({t, " finished in time"}, done_cyc >= 0, 1);
    chk({t, " ar count"}, nar, v.exp_nar);
    if (v.exp_nar > 0) begin
      chk({t, " first araddr"}, a0, v.exp_a0);
      chk({t, " first arlen"}, l0, v.exp_l0);
      chk({t, " last araddr"}, an, v.exp_an);
      chk({t, " last arlen"}, ln, v.exp_ln);
    end
    chk({t, " beats"}, nbeat, v.nbeats);
    chk({t, " data order"}, data_ok, 1);
    chk({t, " out_last"}, last_ok, 1);
    chk({t, " rready tracks out_ready"}, rr_ok, 1);
    chk({t, " out_valid"}, ov_ok, 1);
    chk({t, " ar stable"}, stab_ok, 1);
    chk({t, " ar shape"}, shape_ok, 1);
    chk({t, " done pulses"}, ndone, 1);
    chk({t, " done latency"}, done_cyc - ((v.nbeats == 0) ? 0 : last_cyc), 1);
    chk({t, " err at done"}, err_at_done, v.exp_err);
    chk({t, " err held in idle"}, err, v.exp_err);
  endtask

  initial begin
    logic [1:0] prev;
    //          addr          nb  rnd dly resp nol early nar a0            l0  an            ln  err
    vecs[0] = '{32'h0000_0000, 4,  0, 0,  -1,  -1, -1,   1,  32'h0000_0000, 3,  32'h0000_0000, 3,  2'b00};
    vecs[1] = '{32'h0000_0FC0, 4,  0, 0,  -1,  -1, -1,   2,  32'h0000_0FC0, 1,  32'h0000_1000, 1,  2'b00};
    vecs[2] = '{32'h0000_0000, 40, 0, 0,  -1,  -1, -1,   3,  32'h0000_0000, 15, 32'h0000_0400, 7,  2'b00};
    vecs[3] = '{32'h0000_0100, 24, 1, 3,  -1,  -1, -1,   2,  32'h0000_0100, 15, 32'h0000_0300, 7,  2'b00};
    vecs[4] = '{32'h0000_0000, 20, 0, 0,  1,   0,  -1,   2,  32'h0000_0000, 15, 32'h0000_0200, 3,  2'b11};
    vecs[5] = '{32'h0000_0000, 2,  0, 0,  -1,  -1, -1,   1,  32'h0000_0000, 1,  32'h0000_0000, 1,  2'b00};
    vecs[6] = '{32'h0000_0040, 0,  0, 0,  -1,  -1, -1,   0,  32'h0000_0000, 0,  32'h0000_0000, 0,  2'b00};
    vecs[7] = '{32'h0000_0FE0, 3,  0, 1,  -1,  -1, 1,    2,  32'h0000_0FE0, 0,  32'h0000_1000, 1,  2'b10};
    vecs[8] = '{32'h0000_001F, 1,  0, 0,  -1,  -1, -1,   1,  32'h0000_0000, 0,  32'h0000_0000, 0,  2'b00};
    vecs[9] = '{32'hFFFF_FFE0, 2,  0, 0,  -1,  -1, -1,   2,  32'hFFFF_FFE0, 0,  32'h0000_0000, 0,  2'b00};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("reset");
    rst = 1'b0;

    prev = 2'b00;
    for (int i = 0; i < 10; i++) begin
      run_vec(i, vecs[i], prev);
      prev = vecs[i].exp_err;
    end

    // reset while a burst is in flight in DATA
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 32'h0; req_nbeats = 16'd8;
    m_axi.arready = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("mid arvalid in ADDR", m_axi.arvalid, 1);
    @(posedge clk); #1;
    m_axi.arready = 1'b0; m_axi.rvalid = 1'b1; out_ready = 1'b1;
    #1;
    chk("mid rready in DATA", m_axi.rready, 1);
    chk("mid out_valid in DATA", out_valid, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_quiet("mid reset");
    rst = 1'b0;
    idle_inputs();
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
